// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = 4;
  localparam int unsigned STREAK_W = 4;
  localparam int unsigned STAT_W   = 32;

  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 4;
  localparam int unsigned MAX_D_STREAK_MIN = 1;
  localparam int unsigned MAX_D_STREAK_MAX = 15;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

endpackage

// File: rtl/mem_port_arbiter_tag_pipe.sv
// Fixed-depth shift register of read tags; each entry names the requester
// that owns the memory return arriving DEPTH cycles later.
module arb_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t push_tag,
  output tag_t pop_tag
);

  tag_t pipe_q [DEPTH];
  tag_t pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = push_tag;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign pop_tag = pipe_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Data-priority arbiter sharing one synchronous memory between fetch and load/store.
// Optional MEM_ARB_STATS_EN adds grant / fetch-wait statistics counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_D_STREAK = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [BE_W-1:0]   d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [BE_W-1:0]   mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_i_grants,
  output logic [STAT_W-1:0] stat_d_grants,
  output logic [STAT_W-1:0] stat_i_wait
`endif
);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                force_i;
  tag_t                push_tag, pop_tag;

  assign force_i = (streak_q == STREAK_W'(MAX_D_STREAK));

  // Grant and memory command; reset low suppresses every grant immediately.
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    push_tag  = '0;
    if (reset) begin
      if (d_req && !(i_req && force_i)) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
    if (d_gnt) begin
      mem_en         = 1'b1;
      mem_we         = d_we;
      mem_addr       = d_addr;
      mem_wdata      = d_wdata;
      push_tag.valid = (d_we == '0);
      push_tag.owner = OWNER_D;
    end else if (i_gnt) begin
      mem_en         = 1'b1;
      mem_addr       = i_addr;
      push_tag.valid = 1'b1;
      push_tag.owner = OWNER_I;
    end
  end

  // Consecutive data grants while fetch waits; saturates at the force point.
  always_comb begin
    streak_d = streak_q;
    if (!i_req || i_gnt) begin
      streak_d = '0;
    end else if (d_gnt && !force_i) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  arb_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (reset),
    .push_tag (push_tag),
    .pop_tag  (pop_tag)
  );

  assign i_rvalid = reset && pop_tag.valid && (pop_tag.owner == OWNER_I);
  assign d_rvalid = reset && pop_tag.valid && (pop_tag.owner == OWNER_D);
  assign i_rdata  = reset ? mem_rdata : '0;
  assign d_rdata  = reset ? mem_rdata : '0;

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_i_grants_q, stat_i_grants_d;
  logic [STAT_W-1:0] stat_d_grants_q, stat_d_grants_d;
  logic [STAT_W-1:0] stat_i_wait_q,   stat_i_wait_d;

  always_comb begin
    stat_i_grants_d = stat_i_grants_q + STAT_W'(i_gnt);
    stat_d_grants_d = stat_d_grants_q + STAT_W'(d_gnt);
    stat_i_wait_d   = stat_i_wait_q + STAT_W'(i_req && !i_gnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_i_grants_q <= '0;
      stat_d_grants_q <= '0;
      stat_i_wait_q   <= '0;
    end else begin
      stat_i_grants_q <= stat_i_grants_d;
      stat_d_grants_q <= stat_d_grants_d;
      stat_i_wait_q   <= stat_i_wait_d;
    end
  end

  assign stat_i_grants = stat_i_grants_q;
  assign stat_d_grants = stat_d_grants_q;
  assign stat_i_wait   = stat_i_wait_q;
`endif

endmodule
